// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: core (A) and mul/div (B) requests, dmem handshake,
// and the regfile write port with the hazard-tracking outputs.
interface wb_arbiter_if;
    logic       a_valid;
    logic [1:0] a_src;
    logic [4:0] a_rd;
    logic       a_ready;
    logic       b_valid;
    logic [4:0] b_rd;
    logic       b_ready;
    logic       dmem_ready;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic       pend_valid;
    logic [4:0] pend_rd;
    logic       err;

    modport master (
        output a_valid, a_src, a_rd, b_valid, b_rd, dmem_ready,
        input  a_ready, b_ready, wb_sel, rf_we, rf_waddr, pend_valid, pend_rd, err
    );

    modport slave (
        input  a_valid, a_src, a_rd, b_valid, b_rd, dmem_ready,
        output a_ready, b_ready, wb_sel, rf_we, rf_waddr, pend_valid, pend_rd, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin regfile writeback arbiter between the core pipeline and the
// mul/div unit, with a bounded wait for dmem load data.
module wb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last_b;
    logic [7:0] r_cnt;
    logic [1:0] r_wb_sel;
    logic [4:0] r_waddr;
    logic       r_err;

    logic       w_idle;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_rsvd;
    logic       w_tmo;

    // Grants already include reset, so nothing is accepted while rst is high.
    assign w_idle    = (r_state == IDLE) && !rst;
    assign w_grant_a = w_idle && bus.a_valid && (!bus.b_valid || r_last_b);
    assign w_grant_b = w_idle && bus.b_valid && (!bus.a_valid || !r_last_b);
    assign w_rsvd    = w_grant_a && (bus.a_src == 2'b11);
    assign w_tmo     = (r_state == WAIT_MEM) && !bus.dmem_ready &&
                       (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_a) begin
                    case (bus.a_src)
                        2'b00:   w_next = WAIT_MEM;
                        2'b11:   w_next = IDLE;
                        default: w_next = WRITE;
                    endcase
                end else if (w_grant_b) begin
                    w_next = WRITE;
                end
            end
            WAIT_MEM: begin
                if (bus.dmem_ready) w_next = WRITE;
                else if (w_tmo)     w_next = IDLE;
            end
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are masked by rst so they read zero for the whole reset cycle,
    // not just after the first reset edge.
    always_comb begin
        bus.a_ready    = w_idle && !w_grant_b;
        bus.b_ready    = w_idle && !w_grant_a;
        bus.rf_we      = !rst && (r_state == WRITE) && (r_waddr != 5'd0);
        bus.pend_valid = !rst && ((r_state == WAIT_MEM) || (r_state == WRITE));
        bus.wb_sel     = rst ? 2'b00 : r_wb_sel;
        bus.rf_waddr   = rst ? 5'd0  : r_waddr;
        bus.pend_rd    = rst ? 5'd0  : r_waddr;
        bus.err        = !rst && r_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
            r_cnt    <= 8'd0;
            r_wb_sel <= 2'b00;
            r_waddr  <= 5'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_rsvd || w_tmo;
            if (w_grant_a) begin
                r_last_b <= 1'b0;
                r_wb_sel <= bus.a_src;
                r_waddr  <= bus.a_rd;
            end else if (w_grant_b) begin
                r_last_b <= 1'b1;
                r_wb_sel <= 2'b11;
                r_waddr  <= bus.b_rd;
            end
            if ((r_state == WAIT_MEM) && (w_next == WAIT_MEM)) r_cnt <= r_cnt + 8'd1;
            else                                                 r_cnt <= 8'd0;
        end
    end
endmodule
